// File: rtl/vx_elastic_shift_register_pkg.sv
// rtl/vx_elastic_shift_register_pkg.sv - shared width helper for the elastic shift register
package vx_elastic_shift_register_pkg;

    function automatic int unsigned esr_index_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_elastic_shift_register_stage.sv
// rtl/vx_elastic_shift_register_stage.sv - one pipeline slot: valid bit plus partially reset data
module vx_elastic_shift_register_stage
    import vx_elastic_shift_register_pkg::*;
#(
    parameter int DATAW  = 1,
    parameter int RESETW = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [DATAW-1:0] data_i,
    output logic             valid_o,
    output logic             valid_d_o,
    output logic [DATAW-1:0] data_o
);

    logic valid_q;
    logic valid_d;

    always_comb begin
        valid_d = valid_q;
        if (en_i) begin
            valid_d = valid_i;
        end
        if (flush || reset) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
    end

    assign valid_o   = valid_q;
    assign valid_d_o = valid_d;

    // Only the top RESETW bits carry a reset; the rest stay plain flops.
    if (RESETW == 0) begin : g_noreset
        logic [DATAW-1:0] data_q;
        always_ff @(posedge clk) begin
            if (en_i) begin
                data_q <= data_i;
            end
        end
        assign data_o = data_q;
    end else if (RESETW >= DATAW) begin : g_fullreset
        logic [DATAW-1:0] data_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                data_q <= '0;
            end else if (en_i) begin
                data_q <= data_i;
            end
        end
        assign data_o = data_q;
    end else begin : g_partreset
        logic [RESETW-1:0]       hi_q;
        logic [DATAW-RESETW-1:0] lo_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                hi_q <= '0;
            end else if (en_i) begin
                hi_q <= data_i[DATAW-1 -: RESETW];
            end
        end
        always_ff @(posedge clk) begin
            if (en_i) begin
                lo_q <= data_i[DATAW-RESETW-1:0];
            end
        end
        assign data_o = {hi_q, lo_q};
    end

endmodule

// File: rtl/vx_elastic_shift_register.sv
// rtl/vx_elastic_shift_register.sv - elastic shift register with collapse/lockstep stall and taps
module vx_elastic_shift_register
    import vx_elastic_shift_register_pkg::*;
#(
    parameter int                        DATAW    = 1,
    parameter int                        RESETW   = 0,
    parameter int                        DEPTH    = 2,
    parameter int                        NTAPS    = 1,
    parameter int                        DEPTHW   = esr_index_width(DEPTH),
    parameter logic [NTAPS*DEPTHW-1:0]   TAPS     = {NTAPS{DEPTHW'(DEPTH-1)}},
    parameter int                        COLLAPSE = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         valid_in,
    input  logic [DATAW-1:0]             data_in,
    output logic                         ready_in,
    output logic                         valid_out,
    output logic [DATAW-1:0]             data_out,
    input  logic                         ready_out,
    output logic [NTAPS-1:0]             tap_valid,
    output logic [NTAPS*DATAW-1:0]       tap_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNTW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] stall;
    logic [DATAW-1:0] data_q [DEPTH];
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  count_d;

    // Collapse: a stage only stalls if it is occupied and everything ahead of it stalls.
    if (COLLAPSE != 0) begin : g_collapse
        always_comb begin
            logic run;
            run = ~ready_out;
            stall = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                run      = run & valid_q[i];
                stall[i] = run;
            end
        end
    end else begin : g_lockstep
        assign stall = {DEPTH{valid_q[DEPTH-1] & ~ready_out}};
    end

    assign ready_in = ~stall[0] & ~flush & ~reset;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             prev_valid;
        logic [DATAW-1:0] prev_data;

        if (i == 0) begin : g_head
            assign prev_valid = valid_in & ready_in;
            assign prev_data  = data_in;
        end else begin : g_body
            assign prev_valid = valid_q[i-1];
            assign prev_data  = data_q[i-1];
        end

        vx_elastic_shift_register_stage #(
            .DATAW  (DATAW),
            .RESETW (RESETW)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .en_i      (~stall[i]),
            .valid_i   (prev_valid),
            .data_i    (prev_data),
            .valid_o   (valid_q[i]),
            .valid_d_o (valid_d[i]),
            .data_o    (data_q[i])
        );
    end

    assign valid_out = valid_q[DEPTH-1];
    assign data_out  = data_q[DEPTH-1];

    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CNTW'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        localparam int TI = int'(TAPS[k*DEPTHW +: DEPTHW]);
        assign tap_valid[k]               = valid_q[TI];
        assign tap_data[k*DATAW +: DATAW] = data_q[TI];
    end

endmodule

// File: tb/tb_vx_elastic_shift_register.sv
// tb/tb_vx_elastic_shift_register.sv - directed self-checking bench for the elastic shift register
module tb_vx_elastic_shift_register;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        valid_in;
    logic [7:0]  data_in;
    logic        ready_out;

    logic        col_ready_in, col_valid_out;
    logic [7:0]  col_data_out;
    logic [1:0]  col_tap_valid;
    logic [15:0] col_tap_data;
    logic [2:0]  col_count;

    logic        lk_ready_in, lk_valid_out;
    logic [7:0]  lk_data_out;
    logic [1:0]  lk_tap_valid;
    logic [15:0] lk_tap_data;
    logic [2:0]  lk_count;

    int checks   = 0;
    int failures = 0;
    int maxc;

    always #5 clk = ~clk;

    vx_elastic_shift_register #(
        .DATAW(8), .RESETW(4), .DEPTH(4), .NTAPS(2),
        .TAPS({2'd2, 2'd0}), .COLLAPSE(1)
    ) u_col (
        .clk(clk), .reset(reset), .flush(flush),
        .valid_in(valid_in), .data_in(data_in), .ready_in(col_ready_in),
        .valid_out(col_valid_out), .data_out(col_data_out), .ready_out(ready_out),
        .tap_valid(col_tap_valid), .tap_data(col_tap_data), .count(col_count)
    );

    vx_elastic_shift_register #(
        .DATAW(8), .RESETW(4), .DEPTH(4), .NTAPS(2),
        .TAPS({2'd2, 2'd0}), .COLLAPSE(0)
    ) u_lk (
        .clk(clk), .reset(reset), .flush(flush),
        .valid_in(valid_in), .data_in(data_in), .ready_in(lk_ready_in),
        .valid_out(lk_valid_out), .data_out(lk_data_out), .ready_out(ready_out),
        .tap_valid(lk_tap_valid), .tap_data(lk_tap_data), .count(lk_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        check_eq("rst_ready_in", 32'(col_ready_in), 0);
        check_eq("rst_valid_out", 32'(col_valid_out), 0);
        check_eq("rst_count", 32'(col_count), 0);
        check_eq("rst_tap_valid", 32'(col_tap_valid), 0);
        check_eq("rst_lk_count", 32'(lk_count), 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready_in", 32'(col_ready_in), 1);
        next_cycle();

        // Streaming: 1..8 back to back, output at cycles 4..11.
        maxc = 0;
        for (int c = 0; c < 14; c++) begin
            valid_in = (c < 8); data_in = 8'(c + 1); ready_out = 1'b1;
            @(negedge clk);
            check_eq("stream_valid", 32'(col_valid_out), 32'(c >= 4 && c < 12));
            check_eq("stream_lk_valid", 32'(lk_valid_out), 32'(c >= 4 && c < 12));
            if (c >= 4 && c < 12) begin
                check_eq("stream_data", 32'(col_data_out), 32'(c - 3));
                check_eq("stream_lk_data", 32'(lk_data_out), 32'(c - 3));
            end
            if (int'(col_count) > maxc) maxc = int'(col_count);
            next_cycle();
        end
        check_eq("stream_count_peak", 32'(maxc), 4);

        // A at cycle 0, B at cycle 3, downstream blocked until cycle 8.
        for (int c = 0; c < 13; c++) begin
            valid_in = (c == 0) || (c == 3);
            data_in = (c == 3) ? 8'hB2 : 8'hA1;
            ready_out = (c >= 8);
            @(negedge clk);
            if (c >= 4 && c < 8) begin
                check_eq("col_ready_in_held", 32'(col_ready_in), 1);
                check_eq("lk_ready_in_stall", 32'(lk_ready_in), 0);
            end
            if (c == 7) begin
                check_eq("col_count_two", 32'(col_count), 2);
                check_eq("lk_count_two", 32'(lk_count), 2);
                check_eq("col_head_a", 32'(col_data_out), 32'h A1);
            end
            if (c >= 8) begin
                check_eq("col_vout", 32'(col_valid_out), 32'(c == 8 || c == 9));
                check_eq("lk_vout", 32'(lk_valid_out), 32'(c == 8 || c == 11));
                if (c == 8) check_eq("col_out_a", 32'(col_data_out), 32'hA1);
                if (c == 9) check_eq("col_out_b", 32'(col_data_out), 32'hB2);
                if (c == 8) check_eq("lk_out_a", 32'(lk_data_out), 32'hA1);
                if (c == 11) check_eq("lk_out_b", 32'(lk_data_out), 32'hB2);
            end
            next_cycle();
        end

        // Flush a full pipe; head leaves in the flush cycle, 0x55 is refused.
        for (int c = 0; c < 9; c++) begin
            valid_in = (c <= 4); data_in = (c == 4) ? 8'h55 : 8'(8'h11 + c);
            ready_out = 1'b1; flush = (c == 4);
            @(negedge clk);
            if (c == 4) begin
                check_eq("flush_count_full", 32'(col_count), 4);
                check_eq("flush_head_valid", 32'(col_valid_out), 1);
                check_eq("flush_head_data", 32'(col_data_out), 32'h11);
                check_eq("flush_ready_in", 32'(col_ready_in), 0);
                check_eq("flush_lk_ready_in", 32'(lk_ready_in), 0);
            end
            if (c == 5) begin
                check_eq("flush_count_zero", 32'(col_count), 0);
                check_eq("flush_lk_count_zero", 32'(lk_count), 0);
                check_eq("flush_valid_out", 32'(col_valid_out), 0);
            end
            if (c == 8) check_eq("flush_dropped", 32'(col_valid_out), 0);
            next_cycle();
        end
        flush = 1'b0;

        // Taps: stage 0 on tap 0, stage 2 on tap 1.
        for (int c = 0; c < 6; c++) begin
            valid_in = (c == 0); data_in = 8'h5A; ready_out = 1'b1;
            @(negedge clk);
            if (c == 0) check_eq("tap_idle", 32'(col_tap_valid), 0);
            if (c == 1) begin
                check_eq("tap0_valid", 32'(col_tap_valid), 32'b01);
                check_eq("tap0_data", 32'(col_tap_data[7:0]), 32'h5A);
            end
            if (c == 3) begin
                check_eq("tap1_valid", 32'(col_tap_valid), 32'b10);
                check_eq("tap1_data", 32'(col_tap_data[15:8]), 32'h5A);
            end
            next_cycle();
        end

        // Partial reset of a pipe full of 0xFF.
        for (int c = 0; c < 10; c++) begin
            valid_in = (c < 8); data_in = 8'hFF; ready_out = 1'b0;
            reset = (c == 6) || (c == 7);
            @(negedge clk);
            if (c == 5) check_eq("prst_full", 32'(col_count), 4);
            if (c == 6) check_eq("prst_ready_in_hi", 32'(col_ready_in), 0);
            if (c == 7) begin
                check_eq("prst_valid_out", 32'(col_valid_out), 0);
                check_eq("prst_count", 32'(col_count), 0);
                check_eq("prst_tap_valid", 32'(col_tap_valid), 0);
                check_eq("prst_ready_in", 32'(col_ready_in), 0);
                check_eq("prst_hi_out", 32'(col_data_out[7:4]), 0);
                check_eq("prst_hi_tap0", 32'(col_tap_data[7:4]), 0);
                check_eq("prst_hi_tap1", 32'(col_tap_data[15:12]), 0);
                check_eq("prst_lo_out", 32'(col_data_out[3:0]), 32'hF);
                check_eq("prst_lk_count", 32'(lk_count), 0);
            end
            if (c == 8) check_eq("prst_ready_after", 32'(col_ready_in), 1);
            if (c == 9) begin
                check_eq("prst_ready_after2", 32'(col_ready_in), 1);
                check_eq("prst_nothing_kept", 32'(col_count), 0);
            end
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vx_elastic_shift_register.md
VX_ELASTIC_SHIFT_REGISTER -- requirements
Module: VX_elastic_shift_register

Interface
REQ-001 SHALL have parameter DATAW, default 1, payload width in bits.
REQ-002 SHALL have parameter RESETW, default 0, number of payload MSBs cleared by reset (0..DATAW).
REQ-003 SHALL have parameter DEPTH, default 2, number of stages (>=1).
REQ-004 SHALL have parameter NTAPS, default 1, number of observation taps.
REQ-005 SHALL have parameter DEPTHW, default max(1,clog2(DEPTH)), tap index width.
REQ-006 SHALL have parameter TAPS, default all entries DEPTH-1, packed NTAPS x DEPTHW stage indices.
REQ-007 SHALL have parameter COLLAPSE, default 1, 1 = bubble-collapsing per-stage stall, 0 = lockstep global stall.
REQ-008 SHALL have port clk  input  1  clock.
REQ-009 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-010 SHALL have port flush  input  1  invalidate all stages.
REQ-011 SHALL have ports valid_in input 1, data_in input DATAW, ready_in output 1, forming the upstream handshake.
REQ-012 SHALL have ports valid_out output 1, data_out output DATAW, ready_out input 1, forming the downstream handshake.
REQ-013 SHALL have ports tap_valid output NTAPS and tap_data output NTAPS*DATAW, giving per-tap stage contents.
REQ-014 SHALL have port count  output  clog2(DEPTH+1)  number of occupied stages.

Function
REQ-015 SHALL hold valid_q[i] and data_q[i] per stage; stage 0 loads from input, stage i from stage i-1, and stage DEPTH-1 drives valid_out/data_out.
REQ-016 SHALL, with COLLAPSE=1, define stall[DEPTH-1]=valid_q[DEPTH-1]&~ready_out and stall[i]=valid_q[i]&stall[i+1]; a non-stalled stage loads its predecessor's valid/data.
REQ-017 SHALL, with COLLAPSE=0, use stall=valid_q[DEPTH-1]&~ready_out for all stages; when not stalled, every stage shifts, bubbles included.
REQ-018 SHALL drive ready_in = ~stall[0] & ~flush & ~reset; an upstream transfer occurs on valid_in&ready_in.
REQ-019 SHALL make an accepted item visible on valid_out exactly DEPTH cycles after acceptance when no stall occurs, sustaining 1 item/cycle.
REQ-020 SHALL keep data_out/valid_out stable while valid_out&~ready_out, and never drop or duplicate an item.
REQ-021 SHALL treat data_q of an invalid stage as don't-care; valid_q is authoritative.
REQ-022 SHALL, on flush, clear all valid_q at the next edge; a downstream transfer in the flush cycle completes normally; no input is accepted in that cycle.
REQ-023 SHALL drive tap_valid[k]=valid_q[TAPS[k]] and tap_data[k]=data_q[TAPS[k]] combinationally.
REQ-024 SHALL keep count equal to popcount(valid_q) every cycle, registered, in range 0..DEPTH.
REQ-025 SHALL, with DEPTH=1, reduce to a single registered stage with ready_in=~valid_q[0]|ready_out, flush and reset still gating it.

Reset
REQ-026 SHALL clear all valid_q, count, valid_out and tap_valid on reset; ready_in SHALL be 0 while reset is high.
REQ-027 SHALL clear the top RESETW bits of every data_q on reset and leave the lower DATAW-RESETW bits unreset.
REQ-028 SHALL give reset priority over flush and handshakes, and SHALL discard all in-flight items when reset is applied mid-operation.

Structure
REQ-029 SHALL require no package typedefs; widths are derived locally from parameters using the platform clog2 macro.
REQ-030 SHALL factor out one sub-module, VX_elastic_stage (valid bit plus data register with RESETW partial reset and load enable), instantiated DEPTH times.

Verification
REQ-031 SHALL test streaming: DEPTH=4, data 1..8 on consecutive cycles with ready_out=1 -> valid_out is high at cycles 4..11 carrying 1..8, and count peaks at 4.
REQ-032 SHALL test collapse: DEPTH=4, COLLAPSE=1, items A and B with a 2-cycle gap, ready_out=0 -> both stages fill, count=2 and ready_in stays 1; releasing ready_out yields A then B.
REQ-033 SHALL test lockstep: COLLAPSE=0, the same stimulus -> ready_in=0 once A reaches stage 3, and the gap between A and B is preserved at the output.
REQ-034 SHALL test flush: DEPTH=4 full with ready_out=1, flush pulsed -> the head item transfers in the flush cycle; next cycle count=0 and valid_out=0; valid_in in the flush cycle is dropped.
REQ-035 SHALL test partial reset: DATAW=8, RESETW=4, pipe holding 0xFF, reset -> data_q[*][7:4]=0, valid_out=0, ready_in=0 during reset, ready_in=1 one cycle after reset drops.
REQ-036 SHALL test taps: DEPTH=4, TAPS={0,2}, single item 0x5A accepted -> tap 0 is valid with 0x5A one cycle later, and tap 1 is valid with 0x5A three cycles later.
